// File: rtl/t_ff_bank_pkg.sv
// rtl/t_ff_bank_pkg.sv - shared mode type, per-bit update rule and popcount for t_ff_bank
package t_ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_SET    = 2'b01,
    MODE_CLR    = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_t;

  // Widest vector the popcount helper accepts; callers zero-extend into it.
  localparam int POP_MAX_W = 256;

  // Next value of one flip-flop for an enabled cycle.
  function automatic logic apply_mode(input mode_t mode, input logic q,
                                      input logic t, input logic d);
    logic r;
    case (mode)
      MODE_TOGGLE: r = q ^ t;
      MODE_SET:    r = q | t;
      MODE_CLR:    r = q & ~t;
      default:     r = d;
    endcase
    return r;
  endfunction

  // Number of set bits in v; only the low 'width' bits are examined.
  function automatic logic [31:0] popcount(input logic [POP_MAX_W-1:0] v,
                                           input int width);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (i < width) cnt = cnt + {31'b0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// rtl/t_ff_cell.sv - one toggle/set/clear/load flip-flop with registered rising-edge pulse
module t_ff_cell
  import t_ff_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic       t,
  input  logic       d,
  output logic       q,
  output logic       q_rise
);

  logic q_next;

  // Hold when disabled, otherwise apply the selected operation.
  always_comb begin
    q_next = q;
    if (enable) q_next = apply_mode(mode_t'(mode), q, t, d);
  end

  // State and 0->1 pulse; a held bit never produces a pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q      <= 1'b0;
      q_rise <= 1'b0;
    end else begin
      q      <= q_next;
      q_rise <= ~q & q_next;
    end
  end

endmodule

// File: rtl/t_ff_bank.sv
// rtl/t_ff_bank.sv - WIDTH-bit toggle flip-flop bank; change counter built when T_FF_BANK_CNT_EN is defined
module t_ff_bank
  import t_ff_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [CNT_W-1:0] change_cnt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .mode   (mode),
      .t      (t[i]),
      .d      (d[i]),
      .q      (q[i]),
      .q_rise (q_rise[i])
    );
  end

`ifdef T_FF_BANK_CNT_EN
  localparam int DW = $clog2(WIDTH + 1);
  // Sum is wide enough for both operands so a large delta cannot wrap before clamping.
  localparam int SW = ((CNT_W > DW) ? CNT_W : DW) + 1;
  localparam logic [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [WIDTH-1:0]     q_next;
  logic [POP_MAX_W-1:0] diff_ext;
  logic [DW-1:0]        delta;
  logic [SW-1:0]        sum;

  // The counter sees the same next state the cells compute, so it tracks bit changes exactly.
  always_comb begin
    q_next = q;
    if (enable) begin
      for (int i = 0; i < WIDTH; i++) begin
        q_next[i] = apply_mode(mode_t'(mode), q[i], t[i], d[i]);
      end
    end
    diff_ext = POP_MAX_W'(q ^ q_next);
    delta    = DW'(popcount(diff_ext, WIDTH));
    sum      = SW'(change_cnt) + SW'(delta);
  end

  // Saturating change counter; clear wins over counting and drops this cycle's delta.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      change_cnt <= '0;
    end else if (sum > CNT_MAX) begin
      change_cnt <= CNT_W'(CNT_MAX);
    end else begin
      change_cnt <= CNT_W'(sum);
    end
  end
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = cnt_clr;
  assign change_cnt     = '0;
`endif

endmodule
